quant_int8_nch: RTL and testbench

- Parametrised N-channel requantiser: converts signed 32-bit accumulator words to unsigned 8-bit activations.
- Function per channel: multiply by a fixed-point multiplier, apply a rounded arithmetic right shift, add a zero point, saturate to 0..255.
- Sits between the conv/MAC accumulator array and the activation write-back buffer.
- Additions over the fixed 8-channel version:
  - channel count and widths are parameters;
  - per-channel or shared coefficient mode;
  - valid/ready backpressure through the pipeline;
  - saturation reporting.

---
 rtl/quant_int8_nch_if.sv | 30 +++
 rtl/quant_int8_nch.sv | 133 +++++++++++++
 tb/tb_quant_int8_nch.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/quant_int8_nch_if.sv
// Beat-level bus of the N-channel requantiser: input accumulator beat with its coefficients,
// output activation beat with saturation status.
interface quant_int8_nch_if #(
  parameter int CH_NUM = 8,
  parameter int DATA_W = 32,
  parameter int MULT_W = 15
);
  logic [CH_NUM*DATA_W-1:0] data_in;
  logic                     data_in_vld;
  logic                     data_in_rdy;
  logic [CH_NUM*MULT_W-1:0] mult;
  logic [CH_NUM*8-1:0]      shift;
  logic [7:0]               zero_point;
  logic [CH_NUM*8-1:0]      data_out;
  logic                     data_out_vld;
  logic                     data_out_rdy;
  logic [CH_NUM-1:0]        sat_flag;
  logic [15:0]              sat_cnt;
  logic                     sat_cnt_clr;

  modport master (
    output data_in, data_in_vld, mult, shift, zero_point, data_out_rdy, sat_cnt_clr,
    input  data_in_rdy, data_out, data_out_vld, sat_flag, sat_cnt
  );

  modport slave (
    input  data_in, data_in_vld, mult, shift, zero_point, data_out_rdy, sat_cnt_clr,
    output data_in_rdy, data_out, data_out_vld, sat_flag, sat_cnt
  );
endinterface

// File: rtl/quant_int8_nch.sv
// N-channel int32 -> uint8 requantiser (mult, rounded shift, zero point, clamp); 4-cycle latency.
// One global enable stalls all stages when the output is held; data_in_rdy mirrors that enable.
module quant_int8_nch #(
  parameter int CH_NUM = 8,
  parameter int DATA_W = 32,
  parameter int MULT_W = 15,
  parameter int PER_CH = 0
) (
  input logic              sclk,
  input logic              s_rst,
  quant_int8_nch_if.slave  bus
);
  localparam int PW = DATA_W + MULT_W + 1;
  localparam int SW = $clog2(PW);
  localparam logic [7:0] SMAX = 8'(PW - 1);
  localparam logic signed [PW+1:0] VMAX = (PW+2)'(255);

  logic en;
  logic s1_vld, s2_vld, s3_vld;
  logic [7:0] s1_zp, s2_zp, s3_zp;

  logic signed [DATA_W-1:0] s1_x    [CH_NUM];
  logic [MULT_W-1:0]        s1_m    [CH_NUM];
  logic [SW-1:0]            s1_sh   [CH_NUM];
  logic [SW-1:0]            s2_sh   [CH_NUM];
  logic signed [PW-1:0]     s2_p    [CH_NUM];
  logic signed [PW:0]       s3_r    [CH_NUM];

  logic [MULT_W-1:0]        sel_m   [CH_NUM];
  logic [7:0]               raw_sh  [CH_NUM];
  logic [SW-1:0]            sel_sh  [CH_NUM];
  logic signed [PW-1:0]     prod    [CH_NUM];
  logic signed [PW:0]       rnd_sum [CH_NUM];
  logic signed [PW:0]       rnd_shr [CH_NUM];
  logic signed [PW+1:0]     zp_sum  [CH_NUM];
  logic [CH_NUM*8-1:0]      out_n;
  logic [CH_NUM-1:0]        sat_n;

  logic [6:0]  pop;
  logic        hs;
  logic [15:0] cnt_base;
  logic [16:0] cnt_sum;
  logic        unused_coef;

  assign en              = !bus.data_out_vld || bus.data_out_rdy;
  assign bus.data_in_rdy = en;
  assign unused_coef     = ^{bus.mult, bus.shift};

  // Shared mode reads slice 0 for every channel; shift is clamped to the product width.
  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      sel_m[c]  = bus.mult[((PER_CH != 0) ? c : 0)*MULT_W +: MULT_W];
      raw_sh[c] = bus.shift[((PER_CH != 0) ? c : 0)*8 +: 8];
      sel_sh[c] = (raw_sh[c] > SMAX) ? SMAX[SW-1:0] : raw_sh[c][SW-1:0];
    end
  end

  always_comb begin
    out_n = '0;
    sat_n = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      prod[c]    = PW'(s1_x[c]) * PW'($signed({1'b0, s1_m[c]}));
      // One extra bit keeps p + 2^(s-1) from overflowing.
      rnd_sum[c] = $signed({s2_p[c][PW-1], s2_p[c]}) +
                   $signed(((PW+1)'(1) << s2_sh[c]) >> 1);
      rnd_shr[c] = rnd_sum[c] >>> s2_sh[c];
      zp_sum[c]  = (PW+2)'(s3_r[c]) + $signed((PW+2)'(s3_zp));
      if (zp_sum[c][PW+1]) begin
        out_n[c*8 +: 8] = 8'd0;
        sat_n[c]        = 1'b1;
      end else if (zp_sum[c] > VMAX) begin
        out_n[c*8 +: 8] = 8'd255;
        sat_n[c]        = 1'b1;
      end else begin
        out_n[c*8 +: 8] = zp_sum[c][7:0];
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      s1_vld           <= 1'b0;
      s2_vld           <= 1'b0;
      s3_vld           <= 1'b0;
      bus.data_out_vld <= 1'b0;
      bus.data_out     <= '0;
      bus.sat_flag     <= '0;
    end else if (en) begin
      s1_vld           <= bus.data_in_vld;
      s2_vld           <= s1_vld;
      s3_vld           <= s2_vld;
      bus.data_out_vld <= s3_vld;
      bus.data_out     <= out_n;
      bus.sat_flag     <= sat_n;
    end
  end

  // Datapath registers carry no reset; their contents only matter alongside a set valid bit.
  always_ff @(posedge sclk) begin
    if (en) begin
      s1_zp <= bus.zero_point;
      s2_zp <= s1_zp;
      s3_zp <= s2_zp;
      for (int c = 0; c < CH_NUM; c++) begin
        s1_x[c]  <= bus.data_in[c*DATA_W +: DATA_W];
        s1_m[c]  <= sel_m[c];
        s1_sh[c] <= sel_sh[c];
        s2_p[c]  <= prod[c];
        s2_sh[c] <= s1_sh[c];
        s3_r[c]  <= rnd_shr[c];
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < CH_NUM; c++) pop = pop + 7'(bus.sat_flag[c]);
  end

  assign hs       = bus.data_out_vld && bus.data_out_rdy;
  assign cnt_base = bus.sat_cnt_clr ? 16'd0 : bus.sat_cnt;
  assign cnt_sum  = 17'(cnt_base) + 17'(pop);

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      bus.sat_cnt <= '0;
    end else if (hs) begin
      bus.sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end else if (bus.sat_cnt_clr) begin
      bus.sat_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_quant_int8_nch.sv
// Scoreboard bench: shared-mode instance checked beat by beat, plus a small per-channel instance.
module tb_quant_int8_nch;
  localparam int NA = 8;
  localparam int NB = 32;

  logic sclk = 1'b0;
  logic s_rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   mdl_cnt = 0;
  bit   lat_chk = 1'b1;

  typedef struct {
    logic [NA*8-1:0] dat;
    logic [NA-1:0]   sat;
    int              cyc;
    bit              lat;
  } exp_t;
  exp_t sb[$];

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  quant_int8_nch_if #(.CH_NUM(NA), .DATA_W(32), .MULT_W(15)) ifa();
  quant_int8_nch_if #(.CH_NUM(NB), .DATA_W(32), .MULT_W(15)) ifb();

  quant_int8_nch #(.CH_NUM(NA), .DATA_W(32), .MULT_W(15), .PER_CH(0)) dut_a (
    .sclk(sclk), .s_rst(s_rst), .bus(ifa));
  quant_int8_nch #(.CH_NUM(NB), .DATA_W(32), .MULT_W(15), .PER_CH(1)) dut_b (
    .sclk(sclk), .s_rst(s_rst), .bus(ifb));

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void mdl(input logic signed [31:0] x, input logic [14:0] m,
                              input logic [7:0] sh, input logic [7:0] zp,
                              output logic [7:0] o, output logic s);
    longint xx, mm, zz, p, r, v;
    int sv;
    xx = x;
    mm = m;
    zz = zp;
    p  = xx * mm;
    sv = (sh > 8'd47) ? 47 : int'(sh);
    if (sv > 0) r = (p + (longint'(1) <<< (sv - 1))) >>> sv;
    else        r = p;
    v = r + zz;
    if (v < 0)        begin o = 8'd0;   s = 1'b1; end
    else if (v > 255) begin o = 8'd255; s = 1'b1; end
    else              begin o = v[7:0]; s = 1'b0; end
  endfunction

  function automatic logic [NA*32-1:0] rep(input int x);
    logic [NA*32-1:0] r;
    for (int c = 0; c < NA; c++) r[c*32 +: 32] = x;
    return r;
  endfunction

  // Output checking and expected-value generation for the shared-mode instance.
  always @(negedge sclk) begin : mon
    exp_t e;
    logic [7:0] o;
    logic s;
    if (s_rst) begin
      sb.delete();
      mdl_cnt = 0;
    end else begin
      if (ifa.data_out_vld) begin
        if (sb.size() == 0) chk("spurious_vld", ifa.data_out_vld, 0);
        else begin
          e = sb[0];
          chk("dat", ifa.data_out, e.dat);
          chk("sat", ifa.sat_flag, e.sat);
          if (ifa.data_out_rdy) begin
            if (e.lat) chk("lat", cyc - e.cyc, 4);
            void'(sb.pop_front());
            mdl_cnt = (ifa.sat_cnt_clr ? 0 : mdl_cnt) + $countones(e.sat);
            if (mdl_cnt > 65535) mdl_cnt = 65535;
          end else if (ifa.sat_cnt_clr) mdl_cnt = 0;
        end
      end else if (ifa.sat_cnt_clr) mdl_cnt = 0;
      if (ifa.data_in_vld && ifa.data_in_rdy) begin
        for (int c = 0; c < NA; c++) begin
          mdl(ifa.data_in[c*32 +: 32], ifa.mult[14:0], ifa.shift[7:0], ifa.zero_point, o, s);
          e.dat[c*8 +: 8] = o;
          e.sat[c]        = s;
        end
        e.cyc = cyc;
        e.lat = lat_chk;
        sb.push_back(e);
      end
    end
  end

  task automatic send_a(input logic [NA*32-1:0] din);
    bit acc = 1'b0;
    int n = 0;
    ifa.data_in = din;
    ifa.data_in_vld = 1'b1;
    while (!acc && n < 200) begin
      @(negedge sclk);
      acc = ifa.data_in_rdy;
      @(posedge sclk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 256'(acc), 1);
    ifa.data_in_vld = 1'b0;
  endtask

  task automatic coef_a(input int m, input int sh, input int zp);
    for (int c = 0; c < NA; c++) begin
      ifa.mult[c*15 +: 15] = 15'($urandom);
      ifa.shift[c*8 +: 8]  = 8'($urandom);
    end
    ifa.mult[14:0]     = 15'(m);
    ifa.shift[7:0]     = 8'(sh);
    ifa.zero_point     = 8'(zp);
  endtask

  task automatic drain;
    repeat (10) @(posedge sclk);
    #1;
  endtask

  task automatic clr_pulse;
    ifa.sat_cnt_clr = 1'b1;
    @(posedge sclk); #1;
    ifa.sat_cnt_clr = 1'b0;
  endtask

  task automatic run_b(input string tag, input bit mode);
    logic [NB*8-1:0] ed;
    logic [NB-1:0]   es;
    logic [7:0]      o;
    logic            s;
    int              n = 0;
    for (int c = 0; c < NB; c++) begin
      ifb.mult[c*15 +: 15] = mode ? 15'd256 : 15'(c + 1);
      ifb.shift[c*8 +: 8]  = mode ? 8'(c) : 8'd0;
      ifb.data_in[c*32 +: 32] = 32'd10;
      mdl(32'sd10, ifb.mult[c*15 +: 15], ifb.shift[c*8 +: 8], 8'd0, o, s);
      ed[c*8 +: 8] = o;
      es[c]        = s;
    end
    ifb.zero_point  = 8'd0;
    ifb.data_in_vld = 1'b1;
    @(posedge sclk); #1;
    ifb.data_in_vld = 1'b0;
    while (!ifb.data_out_vld && n < 10) begin
      @(negedge sclk);
      n++;
      if (ifb.data_out_vld) begin
        chk({tag, "_dat"}, ifb.data_out, ed);
        chk({tag, "_sat"}, ifb.sat_flag, es);
      end
    end
    chk({tag, "_vld"}, ifb.data_out_vld, 1);
    @(posedge sclk); #1;
  endtask

  initial begin
    logic [NA*32-1:0] din;
    bit done;
    ifa.data_in = '0; ifa.data_in_vld = 0; ifa.mult = '0; ifa.shift = '0;
    ifa.zero_point = 0; ifa.data_out_rdy = 1; ifa.sat_cnt_clr = 0;
    ifb.data_in = '0; ifb.data_in_vld = 0; ifb.mult = '0; ifb.shift = '0;
    ifb.zero_point = 0; ifb.data_out_rdy = 1; ifb.sat_cnt_clr = 0;

    repeat (3) @(posedge sclk);
    #1;
    @(negedge sclk);
    chk("rst_vld", ifa.data_out_vld, 0);
    chk("rst_dat", ifa.data_out, 0);
    chk("rst_sat", ifa.sat_flag, 0);
    chk("rst_cnt", ifa.sat_cnt, 0);
    chk("rst_vld_b", ifb.data_out_vld, 0);
    @(posedge sclk); #1;
    s_rst = 1'b0;
    @(negedge sclk);
    chk("rdy_after_rst", ifa.data_in_rdy, 1);
    @(posedge sclk); #1;

    // Basic shared-mode beat: expect 110 everywhere.
    coef_a(16384, 15, 10);
    send_a(rep(200));
    drain();

    // Rounding around zero, shift 0, and extreme shift with the widest product.
    coef_a(1, 1, 128);
    din = rep(7);
    din[31:0] = 32'sd3; din[63:32] = -32'sd3; din[95:64] = -32'sd1; din[127:96] = 32'sd5;
    send_a(din);
    coef_a(1, 0, 0);
    send_a(rep(-1));
    coef_a(32767, 47, 0);
    din = rep(32'h8000_0000); din[31:0] = 32'h7fff_ffff;
    send_a(din);
    coef_a(32767, 200, 3);
    send_a(din);
    drain();

    // Saturation at both ends.
    clr_pulse();
    coef_a(1, 0, 0);
    din = rep(0); din[31:0] = -32'sd1000; din[63:32] = 32'sd1000;
    send_a(din);
    drain();
    @(negedge sclk);
    chk("sat_cnt_2", ifa.sat_cnt, 2);
    @(posedge sclk); #1;

    // Eight back-to-back beats with the output stalled for cycles 2..9.
    lat_chk = 1'b0;
    coef_a(3000, 10, 7);
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          for (int c = 0; c < NA; c++) din[c*32 +: 32] = k*1000 - 3000 + c*500;
          send_a(din);
        end
      end
      begin
        repeat (2) @(posedge sclk);
        #1 ifa.data_out_rdy = 1'b0;
        repeat (4) @(posedge sclk);
        @(negedge sclk);
        chk("stall_in_rdy", ifa.data_in_rdy, 0);
        chk("stall_out_vld", ifa.data_out_vld, 1);
        repeat (4) @(posedge sclk);
        #1 ifa.data_out_rdy = 1'b1;
      end
    join
    drain();
    chk("bp_sb_empty", sb.size(), 0);

    // Random coefficients per beat with random downstream stalls.
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          coef_a($urandom_range(0, 32767), $urandom_range(0, 60), $urandom_range(0, 255));
          for (int c = 0; c < NA; c++)
            din[c*32 +: 32] = (k % 2) ? $urandom : 32'($urandom_range(0, 4000)) - 32'd2000;
          send_a(din);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge sclk); #1;
          ifa.data_out_rdy = 1'($urandom_range(0, 1));
        end
        ifa.data_out_rdy = 1'b1;
      end
    join
    drain();
    chk("rand_sb_empty", sb.size(), 0);
    chk("rand_cnt", ifa.sat_cnt, mdl_cnt);

    // Clear coinciding with a handshake keeps that beat's count.
    lat_chk = 1'b1;
    coef_a(1, 0, 0);
    din = rep(5); din[31:0] = -32'sd1000; din[63:32] = 32'sd1000;
    send_a(din);
    for (int n = 0; n < 10 && !ifa.data_out_vld; n++) begin
      @(posedge sclk); #1;
    end
    ifa.sat_cnt_clr = 1'b1;
    @(posedge sclk); #1;
    ifa.sat_cnt_clr = 1'b0;
    @(negedge sclk);
    chk("clr_hs_cnt", ifa.sat_cnt, 2);
    @(posedge sclk); #1;

    // Counter must stick at 0xFFFF.
    coef_a(1, 0, 0);
    for (int k = 0; k < 8200; k++) send_a(rep(-1000));
    drain();
    chk("cnt_max", ifa.sat_cnt, 16'hFFFF);
    chk("cnt_mdl", ifa.sat_cnt, mdl_cnt);
    clr_pulse();
    @(negedge sclk);
    chk("cnt_clr", ifa.sat_cnt, 0);
    @(posedge sclk); #1;

    // Reset with three beats in flight.
    coef_a(16384, 15, 10);
    send_a(rep(300));
    send_a(rep(-300));
    send_a(rep(50));
    s_rst = 1'b1;
    @(posedge sclk); #1;
    s_rst = 1'b0;
    @(negedge sclk);
    chk("midrst_vld", ifa.data_out_vld, 0);
    chk("midrst_cnt", ifa.sat_cnt, 0);
    @(posedge sclk); #1;
    send_a(rep(123));
    drain();
    chk("midrst_sb_empty", sb.size(), 0);

    // Per-channel coefficients.
    run_b("perch_mult", 1'b0);
    run_b("perch_shift", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
